// File: rtl/case8_bist_pkg.sv
// Shared types, tap positions and step functions for the case8 BIST controller.
package case8_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned LFSR_W     = 10;
   localparam int unsigned LFSR_TAP_A = 9;
   localparam int unsigned LFSR_TAP_B = 6;

   localparam int unsigned MISR_W     = 5;
   localparam int unsigned MISR_TAP_A = 4;
   localparam int unsigned MISR_TAP_B = 2;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], v[LFSR_TAP_A] ^ v[LFSR_TAP_B]};
   endfunction

   function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                   input logic [MISR_W-1:0] d);
      return {s[MISR_W-2:0], s[MISR_TAP_A] ^ s[MISR_TAP_B]} ^ d;
   endfunction

endpackage

// File: rtl/misr5.sv
// 5-bit multiple-input signature register; clr wins over en.
module misr5
   import case8_bist_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [MISR_W-1:0] din,
   output logic [MISR_W-1:0] sig
);

   logic [MISR_W-1:0] sig_d;
   logic [MISR_W-1:0] sig_q;

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = misr_step(sig_q, din);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/case8_bist.sv
// BIST controller for the case8 block: LFSR pattern source, pattern counter,
// run FSM and a MISR that compacts the responses into a pass/fail signature.
module case8_bist
   import case8_bist_pkg::*;
#(
   parameter int unsigned       NUM_PATTERNS = 1023,
   parameter logic [LFSR_W-1:0] LFSR_SEED    = 10'h001,
   parameter logic [MISR_W-1:0] GOLDEN_SIG   = 5'h00,
   parameter int unsigned       RESP_LAT     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [MISR_W-1:0] resp_in,
   output logic [LFSR_W-1:0] pat_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [MISR_W-1:0] signature,
   output logic [LFSR_W-1:0] pat_count
);

   localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? 10'h001 : LFSR_SEED;
   localparam logic [LFSR_W-1:0] LAST_IDX = LFSR_W'(NUM_PATTERNS - 1);

   state_e            state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [LFSR_W-1:0] cnt_q, cnt_d;
   logic              pass_q, pass_d;
   logic              clr;
   logic              absorb;
   logic [MISR_W-1:0] sig;

   assign clr = (state_q == IDLE) && start;

   // Responses trail patterns by RESP_LAT cycles; a valid line marks which
   // cycles carry a response that belongs to a pattern of this run.
   if (RESP_LAT == 0) begin : g_lat0
      assign absorb = (state_q == RUN);
   end else begin : g_lat1
      logic valid_d;
      logic valid_q;

      always_comb begin
         valid_d = (state_q == RUN);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
         end
      end

      assign absorb = valid_q;
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               lfsr_d  = SEED_EFF;
               cnt_d   = '0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q == LAST_IDX) begin
               state_d = (RESP_LAT != 0) ? FLUSH : DONE;
            end else begin
               lfsr_d = lfsr_step(lfsr_q);
            end
         end
         FLUSH: state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // The last response is absorbed on the same edge that enters DONE, so
      // the verdict is taken from the MISR's next value rather than its current one.
      if ((state_d == DONE) && (state_q != DONE)) begin
         pass_d = (misr_step(sig, resp_in) == GOLDEN_SIG);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= SEED_EFF;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
      end
   end

   misr5 u_misr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (absorb),
      .din (resp_in),
      .sig (sig)
   );

   assign pat_out   = lfsr_q;
   assign busy      = (state_q == RUN) || (state_q == FLUSH);
   assign done      = (state_q == DONE);
   assign pass      = pass_q;
   assign signature = sig;
   assign pat_count = cnt_q;

endmodule

// File: tb/tb_case8_bist.sv
// Bench for case8_bist: six configurations checked every cycle against a
// cycle-offset model, plus literal expectations for the documented scenarios.
module tb_case8_bist;

   localparam int ND = 6;
   localparam int unsigned CN [ND] = '{8, 3, 3, 3, 1023, 1};
   localparam logic [9:0]  CS [ND] = '{10'h001, 10'h001, 10'h001, 10'h001, 10'h000, 10'h3FF};
   localparam logic [4:0]  CG [ND] = '{5'h00, 5'h07, 5'h00, 5'h07, 5'h00, 5'h00};
   localparam int unsigned CL [ND] = '{0, 0, 0, 1, 0, 1};

   logic       clk = 1'b0;
   logic       rst_v   [ND];
   logic       start_v [ND];
   logic [4:0] resp_v  [ND];
   logic [9:0] pat_v   [ND];
   logic       busy_v  [ND];
   logic       done_v  [ND];
   logic       pass_v  [ND];
   logic [4:0] sig_v   [ND];
   logic [9:0] cnt_v   [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      case8_bist #(
         .NUM_PATTERNS (CN[g]),
         .LFSR_SEED    (CS[g]),
         .GOLDEN_SIG   (CG[g]),
         .RESP_LAT     (CL[g])
      ) u_dut (
         .clk       (clk),
         .rst       (rst_v[g]),
         .start     (start_v[g]),
         .resp_in   (resp_v[g]),
         .pat_out   (pat_v[g]),
         .busy      (busy_v[g]),
         .done      (done_v[g]),
         .pass      (pass_v[g]),
         .signature (sig_v[g]),
         .pat_count (cnt_v[g])
      );
   end

   function automatic logic [9:0] nxt_pat(input logic [9:0] p);
      logic fb;
      fb = p[9] ^ p[6];
      return (p << 1) | {9'b0, fb};
   endfunction

   function automatic logic [4:0] nxt_sig(input logic [4:0] s, input logic [4:0] r);
      logic fb;
      fb = s[4] ^ s[2];
      return ((s << 1) | {4'b0, fb}) ^ r;
   endfunction

   function automatic logic [9:0] seed_of(input int d);
      return (CS[d] == 10'h000) ? 10'h001 : CS[d];
   endfunction

   // Model: m_off is the cycle number since the accepted start (0 = idle).
   bit          m_valid [ND];
   int unsigned m_off   [ND];
   logic [9:0]  m_pat   [ND];
   logic [9:0]  m_cnt   [ND];
   logic [4:0]  m_sig   [ND];
   logic        m_pass  [ND];

   always @(posedge clk) begin
      for (int d = 0; d < ND; d++) begin
         automatic int unsigned o = m_off[d];
         automatic int unsigned n = CN[d];
         automatic int unsigned l = CL[d];
         automatic logic [4:0]  ns = m_sig[d];
         if (rst_v[d]) begin
            m_valid[d] <= 1'b1;
            m_off[d]   <= 0;
            m_cnt[d]   <= '0;
            m_sig[d]   <= '0;
            m_pass[d]  <= 1'b0;
            m_pat[d]   <= seed_of(d);
         end else if (o == 0) begin
            if (start_v[d]) begin
               m_off[d]  <= 1;
               m_cnt[d]  <= '0;
               m_sig[d]  <= '0;
               m_pass[d] <= 1'b0;
               m_pat[d]  <= seed_of(d);
            end
         end else begin
            if (o > l && o <= n + l) ns = nxt_sig(ns, resp_v[d]);
            m_sig[d] <= ns;
            if (o <= n) begin
               m_cnt[d] <= 10'(o);
               if (o < n) m_pat[d] <= nxt_pat(m_pat[d]);
            end
            if (o == n + l) m_pass[d] <= (ns == CG[d]);
            m_off[d] <= (o == n + l + 1) ? 0 : o + 1;
         end
      end
   end

   int errors = 0;
   int checks = 0;
   bit final_req = 1'b0;
   bit final_done = 1'b0;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", nm, d, act, exp, $time);
      end
   endtask

   logic [9:0] lit_seq [8] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h081};
   logic [4:0] lit_sig [3] = '{5'h01, 5'h03, 5'h07};
   int  done_cnt [ND];
   int  bcnt     [ND];
   int  dup4  = 0;
   int  zero4 = 0;
   bit  seen4 [1024];

   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (m_valid[d]) begin
            automatic int unsigned o = m_off[d];
            automatic int unsigned n = CN[d];
            automatic int unsigned l = CL[d];
            automatic logic e_busy = (o >= 1 && o <= n + l);
            automatic logic e_done = (o == n + l + 1);
            chk("busy", d, 32'(busy_v[d]), 32'(e_busy));
            chk("done", d, 32'(done_v[d]), 32'(e_done));
            chk("pat_out", d, 32'(pat_v[d]), 32'(m_pat[d]));
            chk("signature", d, 32'(sig_v[d]), 32'(m_sig[d]));
            chk("pat_count", d, 32'(cnt_v[d]), 32'(m_cnt[d]));
            chk("pass", d, 32'(pass_v[d]), 32'(m_pass[d]));

            if (d == 0 && o >= 1 && o <= 8) chk("seq_lit", d, 32'(pat_v[d]), 32'(lit_seq[o-1]));
            if (d == 1 && o >= 2 && o <= 4) chk("sig_lit", d, 32'(sig_v[d]), 32'(lit_sig[o-2]));
            if (d == 4 && o == 1) chk("first_pat", d, 32'(pat_v[d]), 32'h001);
            if (d == 4 && o >= 1 && o <= n) begin
               if (seen4[pat_v[d]]) dup4++;
               seen4[pat_v[d]] = 1'b1;
               if (pat_v[d] == 10'h000) zero4++;
            end

            if (done_v[d] === 1'b1) begin
               done_cnt[d]++;
               if (d == 0) chk("busy_len", d, 32'(bcnt[d]), 32'd8);
               if (d == 3) chk("busy_len", d, 32'(bcnt[d]), 32'd4);
               if (d == 5) chk("busy_len", d, 32'(bcnt[d]), 32'd2);
               if (d == 1) chk("pass_lit", d, 32'(pass_v[d]), 32'd1);
               if (d == 2) chk("pass_lit", d, 32'(pass_v[d]), 32'd0);
               if (d == 1 || d == 2 || d == 3) chk("final_sig", d, 32'(sig_v[d]), 32'h07);
               if (d == 4) chk("final_cnt", d, 32'(cnt_v[d]), 32'd1023);
               bcnt[d] = 0;
            end else if (busy_v[d] === 1'b1) begin
               bcnt[d]++;
            end else begin
               bcnt[d] = 0;
            end
         end
      end
      if (final_req && !final_done) begin
         chk("done_pulses", 0, 32'(done_cnt[0]), 32'd2);
         chk("done_pulses", 1, 32'(done_cnt[1]), 32'd1);
         chk("done_pulses", 3, 32'(done_cnt[3]), 32'd1);
         chk("done_pulses", 4, 32'(done_cnt[4]), 32'd1);
         chk("done_pulses", 5, 32'(done_cnt[5]), 32'd1);
         chk("dup_patterns", 4, 32'(dup4), 32'd0);
         chk("zero_patterns", 4, 32'(zero4), 32'd0);
         final_done = 1'b1;
      end
   end

   int cyc = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      resp_v[0] = 5'(cyc * 5 + 3);
      resp_v[4] = 5'(cyc ^ (cyc >> 3));
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         rst_v[d]   = 1'b1;
         start_v[d] = 1'b0;
         resp_v[d]  = '0;
      end
      repeat (3) tick();
      for (int d = 0; d < ND; d++) rst_v[d] = 1'b0;
      tick();

      // Sequence run with a stray start during RUN cycle 2.
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      tick();
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      repeat (12) tick();

      // Reset during RUN cycle 4, then a clean run.
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      repeat (3) tick();
      rst_v[0] = 1'b1; tick(); rst_v[0] = 1'b0;
      repeat (3) tick();
      start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
      repeat (12) tick();

      // MISR check with both golden values.
      resp_v[1] = 5'h01;
      resp_v[2] = 5'h01;
      start_v[1] = 1'b1; start_v[2] = 1'b1; tick();
      start_v[1] = 1'b0; start_v[2] = 1'b0;
      repeat (6) tick();

      // Latency-1 run: responses only in the three cycles after the first pattern.
      start_v[3] = 1'b1; tick(); start_v[3] = 1'b0;
      tick();
      resp_v[3] = 5'h01;
      repeat (3) tick();
      resp_v[3] = 5'h00;
      repeat (4) tick();

      // Single-pattern run with latency 1.
      resp_v[5] = 5'h15;
      start_v[5] = 1'b1; tick(); start_v[5] = 1'b0;
      repeat (6) tick();

      // Full-length run from a zero seed.
      start_v[4] = 1'b1; tick(); start_v[4] = 1'b0;
      repeat (1030) tick();

      final_req = 1'b1;
      repeat (2) tick();
      if (!final_done) begin
         errors++;
         $display("FAIL final_checks not reached");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
